// File: rtl/digest_squeeze.sv
// Squeezes 64-bit output words from a Keccak state for SHA3/SHAKE modes,
// requesting further permutations for long SHAKE outputs. Define DIGEST_BYTESWAP_EN for byte-reversed words.
module digest_squeeze (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    c_mode,
    input  logic [15:0]   out_words,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic [3:0]    dout_bytes,
    output logic          perm_req,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WAIT_ST, EMIT, REQ} state_t;
    localparam int MAX_RATE = 21;

    state_t                    state_q, state_d;
    logic [2:0]                mode_q, mode_d;
    logic [15:0]               total_q, total_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [4:0]                idx_q, idx_d;
    logic [MAX_RATE-1:0][63:0] buf_q, buf_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic [4:0]  rate;
    logic        words_left;
    logic        last_word;
    logic        xfer;
    logic        trunc;
    logic [63:0] lane;
    logic [63:0] word;

    // Capacity lanes are never squeezed.
    logic unused_lanes;
    assign unused_lanes = ^state_in[1599:64*MAX_RATE];

    function automatic logic [4:0] rate_of(input logic [2:0] m);
        case (m)
            3'd0:    rate_of = 5'd18;
            3'd1:    rate_of = 5'd17;
            3'd2:    rate_of = 5'd13;
            3'd3:    rate_of = 5'd9;
            3'd4:    rate_of = 5'd21;
            default: rate_of = 5'd17;
        endcase
    endfunction

    function automatic logic [15:0] total_of(input logic [2:0] m, input logic [15:0] n);
        case (m)
            3'd0, 3'd1: total_of = 16'd4;
            3'd2:       total_of = 16'd6;
            3'd3:       total_of = 16'd8;
            default:    total_of = n;
        endcase
    endfunction

    assign rate       = rate_of(mode_q);
    assign words_left = (cnt_q != total_q);
    assign last_word  = ((cnt_q + 16'd1) == total_q);
    assign xfer       = dout_valid && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 3'd0;
            total_q <= 16'd0;
            cnt_q   <= 16'd0;
            idx_q   <= 5'd0;
            buf_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (c_mode > 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = c_mode;
                        total_d = total_of(c_mode, out_words);
                        cnt_d   = 16'd0;
                        idx_d   = 5'd0;
                        // A zero-length SHAKE job never needs a state.
                        state_d = (total_d == 16'd0) ? EMIT : WAIT_ST;
                    end
                end
            end
            WAIT_ST: begin
                if (state_valid) begin
                    for (int k = 0; k < MAX_RATE; k++) begin
                        buf_d[k] = (5'(k) < rate) ? state_in[64*k +: 64] : 64'd0;
                    end
                    idx_d   = 5'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (!words_left) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + 16'd1;
                    idx_d = idx_q + 5'd1;
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if ((idx_q + 5'd1) == rate) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: state_d = WAIT_ST;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_valid = (state_q == EMIT) && words_left;
        trunc      = (mode_q == 3'd0) && (cnt_q == 16'd3);
        lane       = buf_q[idx_q];
        word       = 64'd0;
`ifdef DIGEST_BYTESWAP_EN
        if (trunc) begin
            for (int b = 0; b < 4; b++) word[8*b +: 8] = lane[8*(3-b) +: 8];
        end else begin
            for (int b = 0; b < 8; b++) word[8*b +: 8] = lane[8*(7-b) +: 8];
        end
`else
        word = trunc ? {32'd0, lane[31:0]} : lane;
`endif
        dout       = dout_valid ? word : 64'd0;
        dout_last  = dout_valid && last_word;
        dout_bytes = !dout_valid ? 4'd0 : (trunc ? 4'd4 : 4'd8);
        perm_req   = (state_q == REQ);
        busy       = (state_q != IDLE);
        done       = done_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_digest_squeeze.sv
// Directed-vector bench for digest_squeeze: SHA3 and SHAKE squeezing, stalls,
// permutation requests, illegal modes and mid-job reset.
module tb_digest_squeeze;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    c_mode;
    logic [15:0]   out_words;
    logic [1599:0] state_in;
    logic          state_valid;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic [3:0]    dout_bytes;
    logic          perm_req;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int passes = 0;

    digest_squeeze dut (
        .clk(clk), .rst(rst), .start(start), .c_mode(c_mode), .out_words(out_words),
        .state_in(state_in), .state_valid(state_valid), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .dout_bytes(dout_bytes),
        .perm_req(perm_req), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1599:0] mk_state(input logic [63:0] base);
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) s[64*i +: 64] = base + 64'(i);
        return s;
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] l, input bit trunc);
        logic [63:0] w;
        w = 64'd0;
`ifdef DIGEST_BYTESWAP_EN
        if (trunc) for (int b = 0; b < 4; b++) w[8*b +: 8] = l[8*(3-b) +: 8];
        else       for (int b = 0; b < 8; b++) w[8*b +: 8] = l[8*(7-b) +: 8];
`else
        w = trunc ? {32'd0, l[31:0]} : l;
`endif
        return w;
    endfunction

    task automatic start_job(input logic [2:0] m, input logic [15:0] n);
        c_mode = m; out_words = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed_state(input logic [63:0] base);
        state_in = mk_state(base); state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [73:0] got;
        rst = 1'b1;
        tick(); tick();
        got = {dout, dout_valid, dout_last, dout_bytes, perm_req, busy, done, err};
        checks++;
        if (got !== 74'd0) $display("FAIL reset_outputs: got %h want 0", got); else passes++;
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, err} !== 3'b000) $display("FAIL reset_idle: got %b want 000", {busy, done, err});
        else passes++;
    endtask

    task automatic test_sha3_256();
        logic [69:0] got, want;
        dout_ready = 1'b1;
        start_job(3'd1, 16'd0);
        checks++;
        if ({busy, dout_valid} !== 2'b10) $display("FAIL s256_wait: got %b want 10", {busy, dout_valid});
        else passes++;
        feed_state(64'd1);
        for (int k = 0; k < 4; k++) begin
            got  = {dout_valid, dout, dout_last, dout_bytes};
            want = {1'b1, exp_word(64'(k + 1), 1'b0), (k == 3), 4'd8};
            checks++;
            if (got !== want) $display("FAIL s256_word%0d: got %h want %h", k, got, want); else passes++;
            tick();
        end
        checks++;
        if ({done, busy, dout_valid} !== 3'b100) $display("FAIL s256_done: got %b want 100", {done, busy, dout_valid});
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0) $display("FAIL s256_done_pulse: got %b want 0", done); else passes++;
    endtask

    task automatic test_sha3_224();
        logic [69:0] got, want;
        logic [1599:0] s;
        dout_ready = 1'b1;
        start_job(3'd0, 16'd0);
        s = mk_state(64'd1);
        s[64*3 +: 64] = 64'hAAAA_BBBB_CCCC_DDDD;
        state_in = s; state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = {dout_valid, dout, dout_last, dout_bytes};
            if (k == 3) want = {1'b1, exp_word(64'hAAAA_BBBB_CCCC_DDDD, 1'b1), 1'b1, 4'd4};
            else        want = {1'b1, exp_word(64'(k + 1), 1'b0), 1'b0, 4'd8};
            checks++;
            if (got !== want) $display("FAIL s224_word%0d: got %h want %h", k, got, want); else passes++;
            tick();
        end
        checks++;
        if (done !== 1'b1) $display("FAIL s224_done: got %b want 1", done); else passes++;
        tick();
    endtask

    task automatic test_shake_perm();
        logic [66:0] got, want;
        int bad = 0;
        dout_ready = 1'b1;
        start_job(3'd4, 16'd23);
        feed_state(64'd100);
        for (int k = 0; k < 21; k++) begin
            got  = {dout_valid, dout, dout_last, perm_req};
            want = {1'b1, exp_word(64'(100 + k), 1'b0), 1'b0, 1'b0};
            checks++;
            if (got !== want) begin
                bad++;
                if (bad < 4) $display("FAIL shake_block1_word%0d: got %h want %h", k, got, want);
            end else passes++;
            tick();
        end
        checks++;
        if ({perm_req, dout_valid, busy} !== 3'b101) $display("FAIL shake_req: got %b want 101", {perm_req, dout_valid, busy});
        else passes++;
        tick();
        checks++;
        if ({perm_req, dout_valid, busy} !== 3'b001) $display("FAIL shake_req_pulse: got %b want 001", {perm_req, dout_valid, busy});
        else passes++;
        feed_state(64'd200);
        for (int k = 0; k < 2; k++) begin
            got  = {dout_valid, dout, dout_last, perm_req};
            want = {1'b1, exp_word(64'(200 + k), 1'b0), (k == 1), 1'b0};
            checks++;
            if (got !== want) $display("FAIL shake_block2_word%0d: got %h want %h", k, got, want); else passes++;
            tick();
        end
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL shake_done: got %b want 10", {done, busy}); else passes++;
        tick();
    endtask

    task automatic test_last_at_rate();
        logic [65:0] got, want;
        dout_ready = 1'b1;
        start_job(3'd4, 16'd21);
        feed_state(64'd300);
        for (int k = 0; k < 21; k++) begin
            got  = {dout_valid, dout, dout_last};
            want = {1'b1, exp_word(64'(300 + k), 1'b0), (k == 20)};
            if (k == 0 || k >= 19) begin
                checks++;
                if (got !== want) $display("FAIL rate_end_word%0d: got %h want %h", k, got, want); else passes++;
            end
            tick();
        end
        checks++;
        if ({done, perm_req, busy} !== 3'b100) $display("FAIL rate_end_done: got %b want 100", {done, perm_req, busy});
        else passes++;
        tick();
        checks++;
        if ({done, perm_req, busy} !== 3'b000) $display("FAIL rate_end_idle: got %b want 000", {done, perm_req, busy});
        else passes++;
    endtask

    task automatic test_stall();
        logic [64:0] got, want;
        int n_words = 0;
        int n_done  = 0;
        int n_err   = 0;
        dout_ready = 1'b1;
        start_job(3'd3, 16'd0);
        feed_state(64'd50);
        for (int c = 0; c < 20; c++) begin
            dout_ready = (c % 2 == 0);
            start  = (c == 3);
            c_mode = 3'd0;
            if (dout_valid) begin
                got  = {dout, dout_last};
                want = {exp_word(64'(50 + n_words), 1'b0), (n_words == 7)};
                checks++;
                if (got !== want) $display("FAIL stall_c%0d: got %h want %h", c, got, want); else passes++;
                if (dout_ready) n_words++;
            end
            tick();
            if (done) n_done++;
            if (err) n_err++;
        end
        start = 1'b0;
        dout_ready = 1'b1;
        checks++;
        if (n_words !== 8) $display("FAIL stall_count: got %0d want 8", n_words); else passes++;
        checks++;
        if ({n_done, n_err} !== {32'd1, 32'd0}) $display("FAIL stall_done_err: got %0d/%0d want 1/0", n_done, n_err);
        else passes++;
    endtask

    task automatic test_err_and_zero();
        start_job(3'd7, 16'd5);
        checks++;
        if ({err, busy} !== 2'b10) $display("FAIL err_pulse: got %b want 10", {err, busy}); else passes++;
        tick();
        checks++;
        if ({err, busy} !== 2'b00) $display("FAIL err_clear: got %b want 00", {err, busy}); else passes++;
        start_job(3'd5, 16'd0);
        checks++;
        if ({dout_valid, busy, done} !== 3'b010) $display("FAIL zero_c1: got %b want 010", {dout_valid, busy, done});
        else passes++;
        tick();
        checks++;
        if ({dout_valid, busy, done} !== 3'b001) $display("FAIL zero_done: got %b want 001", {dout_valid, busy, done});
        else passes++;
        tick();
        checks++;
        if (done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", done); else passes++;
    endtask

    task automatic test_rst_mid_job();
        logic [73:0] outs;
        logic [69:0] got, want;
        int n_done = 0;
        dout_ready = 1'b1;
        start_job(3'd1, 16'd0);
        feed_state(64'd1);
        tick();
        checks++;
        if (dout !== exp_word(64'd2, 1'b0)) $display("FAIL rst_word2: got %h want %h", dout, exp_word(64'd2, 1'b0));
        else passes++;
        dout_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        outs = {dout, dout_valid, dout_last, dout_bytes, perm_req, busy, done, err};
        checks++;
        if (outs !== 74'd0) $display("FAIL rst_async_outputs: got %h want 0", outs); else passes++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || busy) n_done++;
        end
        checks++;
        if (n_done !== 0) $display("FAIL rst_no_done: got %0d want 0", n_done); else passes++;
        dout_ready = 1'b1;
        start_job(3'd2, 16'd3);
        feed_state(64'd400);
        for (int k = 0; k < 6; k++) begin
            got  = {dout_valid, dout, dout_last, dout_bytes};
            want = {1'b1, exp_word(64'(400 + k), 1'b0), (k == 5), 4'd8};
            checks++;
            if (got !== want) $display("FAIL rst_m2_word%0d: got %h want %h", k, got, want); else passes++;
            tick();
        end
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL rst_m2_done: got %b want 10", {done, busy}); else passes++;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; c_mode = 3'd0; out_words = 16'd0;
        state_in = '0; state_valid = 1'b0; dout_ready = 1'b0;
        test_reset();
        test_sha3_256();
        test_sha3_224();
        test_shake_perm();
        test_last_at_rate();
        test_stall();
        test_err_and_zero();
        test_rst_mid_job();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/digest_squeeze.md
DIGEST_SQUEEZE -- requirements
Module: digest_squeeze

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a squeeze job.
- c_mode  in  3  mode code: 0 sha3_224, 1 sha3_256, 2 sha3_384, 3 sha3_512, 4 shake_128, 5 shake_256.
- out_words  in  16  SHAKE output length in 64-bit words; ignored for SHA3 modes.
- state_in  in  1600  permuted state; lane i = state_in[64*i+63:64*i].
- state_valid  in  1  one-cycle pulse: state_in holds a fresh permutation result.
- dout  out  64  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout this cycle.
- dout_last  out  1  final word of the job, qualified by dout_valid.
- dout_bytes  out  4  valid low-order bytes in dout, 1..8.
- perm_req  out  1  one-cycle pulse requesting another permutation (SHAKE only).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse when start is given with an illegal c_mode.

Function
REQ-002 The FSM SHALL have four states: IDLE, WAIT_ST, EMIT, REQ.
REQ-003 In IDLE, start SHALL latch c_mode and out_words and move to WAIT_ST; busy SHALL be 1 from the next cycle.
REQ-004 In IDLE, start with c_mode 6 or 7 SHALL pulse err on the next cycle and stay in IDLE; busy SHALL stay 0.
REQ-005 In WAIT_ST, state_valid SHALL copy the rate lanes into an internal buffer, reset the lane index to 0 and move to EMIT. state_valid in any other state SHALL be ignored.
REQ-006 Lane index i in EMIT SHALL drive dout = lane i, with dout_valid = 1 starting the cycle after state_valid (latency 1).
REQ-007 dout, dout_last and dout_bytes SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-008 A transfer SHALL occur when dout_valid and dout_ready are both 1. On a transfer the lane index and the word count SHALL advance by one.
REQ-009 Rate in lanes SHALL be: 18, 17, 13, 9, 21, 17 for modes 0..5.
REQ-010 Words per job SHALL be: 4, 4, 6, 8 for modes 0..3; for modes 4..5 it SHALL be out_words.
REQ-011 For mode 0 the 4th word SHALL carry lane 3 bits [31:0], with dout[63:32] = 0 and dout_bytes = 4. In all other cases dout_bytes SHALL be 8.
REQ-012 dout_last SHALL be 1 on the final word. The cycle after that word's transfer, done SHALL pulse, the FSM SHALL return to IDLE and busy SHALL drop to 0.
REQ-013 If the rate is exhausted (index = rate) with words remaining, the FSM SHALL enter REQ, pulse perm_req for exactly one cycle, then enter WAIT_ST with dout_valid = 0.
REQ-014 A SHAKE job with out_words = 0 SHALL skip WAIT_ST, produce no output, and pulse done two cycles after start.
REQ-015 start while busy SHALL be ignored; the job in progress SHALL be unaffected.
REQ-016 If the final word of a rate block coincides with rate exhaustion, done SHALL take priority and perm_req SHALL NOT pulse.

Reset
REQ-017 rst SHALL force the FSM to IDLE asynchronously and clear the lane index, word counter and buffer.
REQ-018 While in reset, dout = 0, dout_valid = 0, dout_last = 0, dout_bytes = 0, perm_req = 0, busy = 0, done = 0 and err = 0.
REQ-019 rst asserted mid-job SHALL abandon the job with no done pulse. After release the block SHALL accept a new start.

Configuration
REQ-020 With macro DIGEST_BYTESWAP_EN defined, dout SHALL be the byte-reversal of the selected lane; for mode 0 word 4 the valid bytes SHALL be in dout[31:0], byte-reversed within those 4 bytes, with the upper bytes zero. Without the macro, lanes SHALL be output unmodified in little-endian order.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Mode 1, lane i = i+1, dout_ready=1 -> words 1,2,3,4 on consecutive cycles, dout_last on the 4th word, done 1 cycle later.
- Mode 0, lane 3 = 64'hAAAA_BBBB_CCCC_DDDD -> 4th word = 64'h0000_0000_CCCC_DDDD, dout_bytes=4.
- Mode 4, out_words=23 -> 21 words, a perm_req pulse, then after a 2nd state_valid 2 words with dout_last on the 23rd.
- Mode 3 with dout_ready toggled 1/0 -> 8 words, none dropped or duplicated, dout held stable while stalled.
- start with c_mode=7 -> err pulse, busy stays 0; mode 5 with out_words=0 -> done with no dout_valid.
- rst during EMIT at word 2 -> all outputs 0, no done; a new mode 2 job then completes with 6 words.
